tdc_fine_encoder: RTL and testbench
===================================

# tdc_fine_encoder

Fine-phase TDC front end that produces the `tdc_output_finite`, `early` and `fine_done` inputs consumed by the traditional loop filter. It captures the delay-line thermometer word on each `sample_valid`, bubble-corrects and pop-counts it, and averages 2^AVG_LOG2 same-sign samples. It then presents an 11-bit magnitude plus sign and issues a widened `fine_done` strobe. The data is stable before the strobe's rising edge because the downstream filter samples on `posedge fine_done`.

## Interface
Parameters:
- THERM_W, 64, delay-line taps; legal range 8..64.
- AVG_LOG2, 2, log2 of the samples averaged per result; legal range 0..3.
- STROBE_CYC, 4, `fine_done` high time in clk cycles; minimum 2.

Ports:
- clk  in  1  sampling clock; the delay-line strobe is synchronous to it.
- fine_done_with_reset  in  1  reset, asynchronous, active-high.
- enable  in  1  1 = accept samples; 0 = finish the current strobe, then idle with the accumulator cleared.
- sample_valid  in  1  single-cycle pulse; `therm` and `lead_lag` are valid in the same cycle.
- therm  in  THERM_W  thermometer word; bit 0 is the nearest tap, 1 = edge passed.
- lead_lag  in  1  1 = feedback edge early relative to reference.
- tdc_output_finite  out  11  averaged magnitude in format 7.4 (integer taps, 4 fractional bits).
- early  out  1  sign of the window.
- fine_done  out  1  result strobe.
- busy  out  1  high from window completion until the strobe ends.
- dropped  out  1  sticky; set when `sample_valid` is ignored.

## Operation
- FSM states: IDLE, ENC, ACC, OUT, STROBE.
- IDLE: on `sample_valid & enable`, register `therm` and `lead_lag`, then go to ENC. `sample_valid` in any other state, or with `enable`=0, is ignored and sets `dropped`.
- ENC: bubble correction `c[i] = maj(t[i-1], t[i], t[i+1])`, with `t[-1]=1` and `t[THERM_W]=0`. `cnt` = popcount(c), range 0..THERM_W, registered. Go to ACC.
- ACC: the window sign is latched from the first sample of the window.
  - Sign mismatch: clear the accumulator, load `acc=cnt`, set `n=1`, take the new sign as the window sign, go to IDLE.
  - Sign match: `acc += cnt`, `n += 1`. If `n` reaches 2^AVG_LOG2, go to OUT; else go to IDLE.
- Accumulator width is 10 bits, unsigned, and cannot overflow (64×8 = 512).
- OUT:
  - `tdc_output_finite = {(acc >> AVG_LOG2), 4'b0}`, truncating; maximum value is 1024.
  - `early` = window sign.
  - Clear `acc` and `n`, assert `busy`, go to STROBE.
- STROBE: `fine_done`=1 for STROBE_CYC cycles, then return to IDLE with `busy`=0.
- `tdc_output_finite` and `early` change only in OUT. They hold until the next OUT.
- `enable` falling mid-window discards the partial window. It does not affect OUT or STROBE in progress.
- `dropped` clears only on reset.

## Timing
- Reset values: `tdc_output_finite`=0, `early`=0, `fine_done`=0, `busy`=0, `dropped`=0, FSM=IDLE, `acc`=0, `n`=0.
- Edge E0 samples the last `sample_valid` of a window:
  - E1: ENC.
  - E2: ACC.
  - E3: outputs update.
  - E4: `fine_done` rises.
  - E4+STROBE_CYC: `fine_done` falls.
  - Data has 1 cycle of setup before `fine_done` rises and holds for the whole strobe.
- Minimum sample spacing is 3 cycles, or STROBE_CYC+4 across a window boundary. Faster samples are dropped.
- Reset asserted mid-operation clears every output immediately, without waiting for a clk edge, including a `fine_done` that is high. The FSM restarts in IDLE with an empty window.
- Everything is on the clk domain. The downstream `posedge fine_done` consumer sees exactly one rising edge per result.

## Test plan
- AVG_LOG2=2: 4 samples with `therm`=0x00000000000FFFFF and `lead_lag`=1, 3 cycles apart -> `tdc_output_finite`=320, `early`=1. `fine_done` is high for cycles E4..E7 after the 4th sample, and `busy` is high from E3 until `fine_done` falls.
- Bubble: 4 samples with `therm`=0x000000000000FBFF -> correction fills bit 10 and the count is 16, so `tdc_output_finite`=256.
- Sign flip: `lead_lag` sequence 1,1,0,0,0,0 with count 10 each -> a single strobe after the 6th sample with `early`=0 and `tdc_output_finite`=160.
- Saturation/truncation: all-ones `therm` ×4 -> 1024. Counts 3,3,3,4 -> `acc`=13 and the output is `3<<4`=48.
- Drop: `sample_valid` one cycle after an accepted sample -> `dropped`=1, and the result is unaffected by the extra sample.
- Reset mid-strobe: assert `fine_done_with_reset` while `fine_done`=1 -> all outputs are 0 before the next clk edge. After release, 4 fresh samples produce a normal result.

Source files
------------

// File: rtl/tdc_fine_encoder.sv
// rtl/tdc_fine_encoder.sv - fine-phase TDC encoder: bubble-corrected thermometer
// pop-count, same-sign averaging and a widened fine_done result strobe.
module tdc_fine_encoder #(
  parameter int THERM_W    = 64,
  parameter int AVG_LOG2   = 2,
  parameter int STROBE_CYC = 4
) (
  input  logic               clk,
  input  logic               fine_done_with_reset,
  input  logic               enable,
  input  logic               sample_valid,
  input  logic [THERM_W-1:0] therm,
  input  logic               lead_lag,
  output logic [10:0]        tdc_output_finite,
  output logic               early,
  output logic               fine_done,
  output logic               busy,
  output logic               dropped
);

  localparam int CNT_W = $clog2(THERM_W + 1);
  localparam int N_TGT = 1 << AVG_LOG2;
  localparam int SC_W  = (STROBE_CYC > 2) ? $clog2(STROBE_CYC) : 1;

  typedef enum logic [2:0] {IDLE, ENC, ACC, OUT, STROBE} state_t;

  state_t             state, state_nxt;
  logic [THERM_W-1:0] therm_q;
  logic               sign_q;
  logic [CNT_W-1:0]   cnt_q, pop;
  logic [THERM_W+1:0] ext;
  logic [9:0]         acc_q, acc_nxt;
  logic [3:0]         n_q, n_nxt, n_inc;
  logic               win_sign, win_nxt;
  logic [SC_W-1:0]    scnt;
  logic               accept, drop, mismatch;

  assign n_inc    = n_q + 4'd1;
  assign mismatch = (n_q != 4'd0) && (sign_q != win_sign);

  // Majority vote over neighbours, edges padded as "passed" below bit 0 and "not passed" above the top tap.
  always_comb begin
    ext = {1'b0, therm_q, 1'b1};
    pop = '0;
    for (int i = 0; i < THERM_W; i++) begin
      pop = pop + CNT_W'((ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]));
    end
  end

  always_ff @(posedge clk or posedge fine_done_with_reset) begin
    if (fine_done_with_reset) state <= IDLE;
    else                      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_valid && enable) state_nxt = ENC;
      ENC:     state_nxt = ACC;
      ACC: begin
        if (!enable)                          state_nxt = IDLE;
        else if (mismatch)                    state_nxt = (N_TGT == 1) ? OUT : IDLE;
        else if (n_inc == 4'(N_TGT))          state_nxt = OUT;
        else                                  state_nxt = IDLE;
      end
      OUT:     state_nxt = STROBE;
      STROBE:  if (scnt == SC_W'(STROBE_CYC - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept  = (state == IDLE) && sample_valid && enable;
    drop    = sample_valid && !accept;
    acc_nxt = acc_q;
    n_nxt   = n_q;
    win_nxt = win_sign;
    case (state)
      IDLE: begin
        if (!enable) begin
          acc_nxt = '0;
          n_nxt   = '0;
        end
      end
      ACC: begin
        if (!enable) begin
          acc_nxt = '0;
          n_nxt   = '0;
        end else if (n_q == 4'd0 || mismatch) begin
          acc_nxt = 10'(cnt_q);
          n_nxt   = 4'd1;
          win_nxt = sign_q;
        end else begin
          acc_nxt = acc_q + 10'(cnt_q);
          n_nxt   = n_inc;
        end
      end
      OUT: begin
        acc_nxt = '0;
        n_nxt   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge fine_done_with_reset) begin
    if (fine_done_with_reset) begin
      therm_q           <= '0;
      sign_q            <= 1'b0;
      cnt_q             <= '0;
      acc_q             <= '0;
      n_q               <= '0;
      win_sign          <= 1'b0;
      scnt              <= '0;
      tdc_output_finite <= '0;
      early             <= 1'b0;
      fine_done         <= 1'b0;
      busy              <= 1'b0;
      dropped           <= 1'b0;
    end else begin
      if (accept) begin
        therm_q <= therm;
        sign_q  <= lead_lag;
      end
      if (state == ENC) cnt_q <= pop;
      acc_q    <= acc_nxt;
      n_q      <= n_nxt;
      win_sign <= win_nxt;
      if (state == OUT) begin
        tdc_output_finite <= 11'({acc_q >> AVG_LOG2, 4'b0000});
        early             <= win_sign;
      end
      scnt      <= (state == STROBE) ? scnt + SC_W'(1) : '0;
      // Registered one cycle behind the state so data leads the strobe by a cycle.
      fine_done <= (state == STROBE);
      busy      <= (state == STROBE) || (state_nxt == STROBE);
      if (drop) dropped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tdc_fine_encoder.sv
// tb/tb_tdc_fine_encoder.sv - scoreboard bench for tdc_fine_encoder.
module tb_tdc_fine_encoder;

  localparam int THERM_W = 64;
  localparam int SC      = 4;

  logic               clk = 1'b0;
  logic               fine_done_with_reset = 1'b1;
  logic               enable = 1'b1;
  logic               sample_valid = 1'b0;
  logic [THERM_W-1:0] therm = '0;
  logic               lead_lag = 1'b0;
  logic [10:0]        tdc_output_finite;
  logic               early, fine_done, busy, dropped;

  int vectors = 0;
  int miscompares = 0;
  int strobes = 0;
  logic prev_fd = 1'b0;
  logic [11:0] exp_q[$];
  logic [11:0] e;

  tdc_fine_encoder #(.THERM_W(THERM_W), .AVG_LOG2(2), .STROBE_CYC(SC)) dut (
    .clk(clk), .fine_done_with_reset(fine_done_with_reset), .enable(enable),
    .sample_valid(sample_valid), .therm(therm), .lead_lag(lead_lag),
    .tdc_output_finite(tdc_output_finite), .early(early), .fine_done(fine_done),
    .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  // Scoreboard: every rising fine_done pops one expected {early, magnitude}.
  always @(negedge clk) begin
    if (fine_done && !prev_fd) begin
      strobes++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe early=%0b tdc=%0d", early, tdc_output_finite);
      end else begin
        e = exp_q.pop_front();
        if ({early, tdc_output_finite} !== e) begin
          miscompares++;
          $display("FAIL result got early=%0b tdc=%0d want early=%0b tdc=%0d",
                   early, tdc_output_finite, e[11], e[10:0]);
        end
      end
    end
    prev_fd = fine_done;
  end

  task automatic send(input logic [THERM_W-1:0] t, input logic ll);
    therm = t; lead_lag = ll; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_window();
    int k;
    @(negedge clk);
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy && !fine_done) break;
    end
    if (k == 60) begin
      vectors++; miscompares++;
      $display("FAIL window_timeout busy=%0b fine_done=%0b want 0", busy, fine_done);
    end
  endtask

  task automatic check_strobes(input string name, input int want);
    vectors++;
    if (strobes !== want) begin
      miscompares++;
      $display("FAIL %s strobes got %0d want %0d", name, strobes, want);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({tdc_output_finite, early, fine_done, busy, dropped} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_state got tdc=%0d early=%0b fd=%0b busy=%0b dropped=%0b want all 0",
               tdc_output_finite, early, fine_done, busy, dropped);
    end
    fine_done_with_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int s0;
    s0 = strobes;
    exp_q.push_back({1'b1, 11'd320});
    repeat (3) send(64'h00000000000FFFFF, 1'b1);
    therm = 64'h00000000000FFFFF; lead_lag = 1'b1; sample_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) sample_valid = 1'b0;
      vectors++;
      if (fine_done !== (k >= 4 && k <= 7)) begin
        miscompares++;
        $display("FAIL basic_fine_done E%0d got %0b want %0b", k, fine_done, (k >= 4 && k <= 7));
      end
      vectors++;
      if (busy !== (k >= 3 && k <= 7)) begin
        miscompares++;
        $display("FAIL basic_busy E%0d got %0b want %0b", k, busy, (k >= 3 && k <= 7));
      end
      if (k == 3) begin
        vectors++;
        if (tdc_output_finite !== 11'd320) begin
          miscompares++;
          $display("FAIL basic_setup E3 tdc got %0d want 320", tdc_output_finite);
        end
      end
    end
    check_strobes("basic", s0 + 1);
  endtask

  task automatic run_window(input string name, input logic [THERM_W-1:0] t0, input logic [THERM_W-1:0] t3,
                            input logic ll, input logic [10:0] want);
    int s0;
    s0 = strobes;
    exp_q.push_back({ll, want});
    repeat (3) send(t0, ll);
    send(t3, ll);
    wait_window();
    check_strobes(name, s0 + 1);
  endtask

  task automatic test_bubble();
    run_window("bubble", 64'h000000000000FBFF, 64'h000000000000FBFF, 1'b0, 11'd256);
  endtask

  task automatic test_saturation();
    run_window("saturation", {THERM_W{1'b1}}, {THERM_W{1'b1}}, 1'b1, 11'd1024);
  endtask

  task automatic test_truncation();
    run_window("truncation", 64'h7, 64'hF, 1'b0, 11'd48);
  endtask

  task automatic test_sign_flip();
    int s0;
    s0 = strobes;
    send(64'h3FF, 1'b1);
    send(64'h3FF, 1'b1);
    exp_q.push_back({1'b0, 11'd160});
    repeat (4) send(64'h3FF, 1'b0);
    wait_window();
    check_strobes("sign_flip", s0 + 1);
  endtask

  task automatic test_drop();
    int s0;
    s0 = strobes;
    vectors++;
    if (dropped !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_before got %0b want 0", dropped);
    end
    exp_q.push_back({1'b1, 11'd128});
    therm = 64'hFF; lead_lag = 1'b1; sample_valid = 1'b1;
    @(negedge clk);
    therm = {THERM_W{1'b1}}; lead_lag = 1'b0;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (dropped !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_sticky got %0b want 1", dropped);
    end
    repeat (3) send(64'hFF, 1'b1);
    wait_window();
    check_strobes("drop", s0 + 1);
  endtask

  task automatic test_reset_mid_strobe();
    int s0;
    int k;
    exp_q.push_back({1'b1, 11'd128});
    repeat (4) send(64'hFF, 1'b1);
    for (k = 0; k < 30; k++) begin
      if (fine_done) break;
      @(negedge clk);
    end
    vectors++;
    if (fine_done !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_strobe_reach fine_done got %0b want 1", fine_done);
    end
    #2 fine_done_with_reset = 1'b1;
    #1;
    vectors++;
    if ({tdc_output_finite, early, fine_done, busy, dropped} !== 15'd0) begin
      miscompares++;
      $display("FAIL async_reset got tdc=%0d early=%0b fd=%0b busy=%0b dropped=%0b want all 0",
               tdc_output_finite, early, fine_done, busy, dropped);
    end
    @(negedge clk);
    fine_done_with_reset = 1'b0;
    @(negedge clk);
    s0 = strobes;
    run_window("after_reset", 64'hFFFF, 64'hFFFF, 1'b0, 11'd256);
    vectors++;
    if (strobes !== s0 + 1 || dropped !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset strobes got %0d dropped %0b want %0d 0", strobes, dropped, s0 + 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubble();
    test_sign_flip();
    test_saturation();
    test_truncation();
    test_drop();
    test_reset_mid_strobe();
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
